reg_dump_uart_tx: RTL and testbench

//  Debug read-out engine for the 8x16 register file. On request it walks register

---
 rtl/reg_dump_uart_tx.sv | 126 ++++++++++++
 tb/tb_reg_dump_uart_tx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_uart_tx.sv
// Debug read-out engine: walks register addresses 0..NUM_REGS-1 through one read port
// and sends each 16-bit value over an 8N1 UART line, high byte first.
module reg_dump_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned NUM_REGS     = 8,
    parameter int unsigned ADDR_W       = 3,
    parameter int unsigned DATA_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dump_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(NUM_REGS - 1);
    localparam logic [3:0]        BIT_LAST  = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET_ADDR,
        S_LATCH,
        S_SEND_HI,
        S_SEND_LO,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_shadow;
    logic [BAUD_W-1:0] r_baud;
    logic [3:0]        r_bit;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;

    logic [7:0]        w_byte;
    logic [9:0]        w_frame;
    logic [3:0]        w_next_bit;

    // Frame layout, index = bit counter: start, d0..d7, stop.
    always_comb begin
        w_byte     = (r_state == S_SEND_HI) ? r_shadow[15:8] : r_shadow[7:0];
        w_frame    = {1'b1, w_byte, 1'b0};
        w_next_bit = r_bit + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shadow  <= '0;
            r_baud    <= '0;
            r_bit     <= '0;
            r_idx     <= '0;
            r_rd_addr <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (dump_req) begin
                        r_state   <= S_SET_ADDR;
                        r_busy    <= 1'b1;
                        r_idx     <= '0;
                        r_rd_addr <= '0;
                    end
                end
                S_SET_ADDR: r_state <= S_LATCH;
                // Start bit is loaded here so tx is low on the first SEND_HI cycle.
                S_LATCH: begin
                    r_shadow <= rd_data;
                    r_tx     <= 1'b0;
                    r_baud   <= '0;
                    r_bit    <= '0;
                    r_state  <= S_SEND_HI;
                end
                S_SEND_HI, S_SEND_LO: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud <= '0;
                        if (r_bit == BIT_LAST) begin
                            r_bit <= '0;
                            if (r_state == S_SEND_HI) begin
                                r_state <= S_SEND_LO;
                                r_tx    <= 1'b0;
                            end else if (r_idx == IDX_LAST) begin
                                r_state   <= S_DONE;
                                r_busy    <= 1'b0;
                                r_done    <= 1'b1;
                                r_tx      <= 1'b1;
                                r_idx     <= '0;
                                r_rd_addr <= '0;
                            end else begin
                                r_state   <= S_SET_ADDR;
                                r_tx      <= 1'b1;
                                r_idx     <= r_idx + 1'b1;
                                r_rd_addr <= r_idx + 1'b1;
                            end
                        end else begin
                            r_bit <= w_next_bit;
                            r_tx  <= w_frame[w_next_bit];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_addr = r_rd_addr;
    assign tx      = r_tx;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_reg_dump_uart_tx.sv
// Directed bench for reg_dump_uart_tx: records tx/busy/done/rd_addr per cycle during a
// dump, decodes the UART bytes and compares against hand-derived waveforms.
module tb_reg_dump_uart_tx;

    localparam int CPB      = 4;
    localparam int FRAME    = 10 * CPB;
    localparam int REG_CYC  = 2 + 2 * FRAME;
    localparam int DUMP_CYC = 8 * REG_CYC;
    localparam int NCYC     = DUMP_CYC + 14;

    logic        clk = 1'b0;
    logic        rst;
    logic        dump_req;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic        tx;
    logic        busy;
    logic        done;

    logic [15:0] rf [8];
    assign rd_data = rf[rd_addr];

    int n_assert = 0;
    int n_fail   = 0;

    logic       tx_tr   [1:NCYC];
    logic       busy_tr [1:NCYC];
    logic       done_tr [1:NCYC];
    logic [2:0] addr_tr [1:NCYC];
    logic [7:0] exp_b [16];
    logic [7:0] got_b [32];

    reg_dump_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .NUM_REGS    (8),
        .ADDR_W      (3),
        .DATA_W      (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .dump_req(dump_req),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_rf();
        rf[0] = 16'h0000; rf[1] = 16'h1234; rf[2] = 16'h5678; rf[3] = 16'h9ABC;
        rf[4] = 16'hDEF0; rf[5] = 16'h0F0F; rf[6] = 16'hA5A5; rf[7] = 16'hBEEF;
    endtask

    task automatic set_exp();
        exp_b = '{8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC,
                  8'hDE, 8'hF0, 8'h0F, 8'h0F, 8'hA5, 8'hA5, 8'hBE, 8'hEF};
    endtask

    // Expected line level in cycle k after the request edge (k=1 is SET_ADDR of r0).
    function automatic logic exp_tx(input int k);
        int r, off, bitn;
        logic [7:0] b;
        if (k > DUMP_CYC) return 1'b1;
        r   = (k - 1) / REG_CYC;
        off = (k - 1) % REG_CYC;
        if (off < 2) return 1'b1;
        off  = off - 2;
        b    = exp_b[2 * r + off / FRAME];
        bitn = (off % FRAME) / CPB;
        if (bitn == 0) return 1'b0;
        if (bitn == 9) return 1'b1;
        return b[bitn - 1];
    endfunction

    task automatic run_dump(input int ncyc, input int req2_k, input int wr_k,
                            input logic [15:0] w7, input logic [15:0] w1);
        @(negedge clk);
        dump_req = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            tx_tr[k]   = tx;
            busy_tr[k] = busy;
            done_tr[k] = done;
            addr_tr[k] = rd_addr;
            dump_req   = (k == req2_k);
            if (k == wr_k) begin
                rf[7] = w7;
                rf[1] = w1;
            end
        end
        dump_req = 1'b0;
    endtask

    task automatic check_dump(input string tag);
        int n_got, framing, k, mism, nb, nd;
        logic [7:0] b;
        n_got = 0; framing = 0; k = 1;
        foreach (got_b[i]) got_b[i] = '0;
        while (k <= NCYC - FRAME) begin
            if (tx_tr[k] === 1'b0) begin
                if (tx_tr[k + CPB / 2] !== 1'b0) framing++;
                for (int j = 0; j < 8; j++) b[j] = tx_tr[k + CPB / 2 + CPB * (j + 1)];
                if (tx_tr[k + CPB / 2 + CPB * 9] !== 1'b1) framing++;
                if (n_got < 32) got_b[n_got] = b;
                n_got++;
                k += FRAME;
            end else begin
                k++;
            end
        end
        check($sformatf("%s byte_count", tag), n_got, 16);
        check($sformatf("%s framing", tag), framing, 0);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s byte%0d", tag, i), got_b[i], exp_b[i]);
        for (int r = 0; r < 8; r++) begin
            mism = 0;
            for (int off = 0; off < REG_CYC; off++)
                if (tx_tr[1 + r * REG_CYC + off] !== exp_tx(1 + r * REG_CYC + off)) mism++;
            check($sformatf("%s tx_timing_r%0d", tag, r), mism, 0);
            check($sformatf("%s rd_addr_set_r%0d", tag, r), addr_tr[1 + r * REG_CYC], r);
            check($sformatf("%s rd_addr_latch_r%0d", tag, r), addr_tr[2 + r * REG_CYC], r);
        end
        nb = 0; nd = 0;
        for (int i = 1; i <= NCYC; i++) begin
            if (busy_tr[i] === 1'b1) nb++;
            if (done_tr[i] === 1'b1) nd++;
        end
        check($sformatf("%s busy_cycles", tag), nb, DUMP_CYC);
        check($sformatf("%s done_pulses", tag), nd, 1);
        check($sformatf("%s busy_first", tag), busy_tr[1], 1);
        check($sformatf("%s busy_last", tag), busy_tr[DUMP_CYC], 1);
        check($sformatf("%s done_cycle", tag), done_tr[DUMP_CYC + 1], 1);
        check($sformatf("%s busy_at_done", tag), busy_tr[DUMP_CYC + 1], 0);
        check($sformatf("%s addr_at_done", tag), addr_tr[DUMP_CYC + 1], 0);
        check($sformatf("%s tx_at_done", tag), tx_tr[DUMP_CYC + 1], 1);
    endtask

    initial begin
        rst      = 1'b1;
        dump_req = 1'b0;
        load_rf();
        set_exp();
        #1;
        check("por tx", tx, 1);
        check("por busy", busy, 0);
        check("por done", done, 0);
        check("por rd_addr", rd_addr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        run_dump(NCYC, -1, -1, 16'h0, 16'h0);
        check_dump("plain");

        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("idle_rst tx", tx, 1);
        check("idle_rst busy", busy, 0);
        check("idle_rst done", done, 0);
        check("idle_rst rd_addr", rd_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_dump(NCYC, 1 + 3 * REG_CYC + 10, -1, 16'h0, 16'h0);
        check_dump("req_while_busy");

        repeat (3) @(negedge clk);
        exp_b[14] = 8'h11;
        exp_b[15] = 8'h11;
        run_dump(NCYC, -1, 1 + 2 * REG_CYC + 30, 16'h1111, 16'h2222);
        check_dump("late_write");
        load_rf();
        set_exp();

        repeat (3) @(negedge clk);
        run_dump(1 + 4 * REG_CYC + 4, -1, -1, 16'h0, 16'h0);
        check("abort pre tx", tx_tr[1 + 4 * REG_CYC + 4], 0);
        check("abort pre rd_addr", addr_tr[1 + 4 * REG_CYC + 4], 4);
        check("abort pre busy", busy_tr[1 + 4 * REG_CYC + 4], 1);
        #2 rst = 1'b1;
        #1;
        check("abort tx", tx, 1);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort rd_addr", rd_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_abort idle busy", busy, 0);
        check("post_abort idle tx", tx, 1);
        run_dump(NCYC, -1, -1, 16'h0, 16'h0);
        check_dump("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
